// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and byte-lane helpers for the fetch/data memory-port arbiter.
// Lane 0 carries the most significant byte of a word (big-endian).
package mem_arb_pkg;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} arb_state_e;
  typedef enum logic [1:0] {GNT_NONE, GNT_IF, GNT_D} grant_e;

  typedef logic [3:0][7:0] lanes_t;

  function automatic lanes_t pack_lanes(input logic [31:0] word);
    lanes_t l;
    l[0] = word[31:24];
    l[1] = word[23:16];
    l[2] = word[15:8];
    l[3] = word[7:0];
    return l;
  endfunction

  function automatic logic [31:0] unpack_lanes(input lanes_t l);
    return {l[0], l[1], l[2], l[3]};
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Request/response channels for fetch and load/store plus the shared memory port.
// slave = arbiter view, master = requesters and memory model view.
interface mem_port_arbiter_if;
  import mem_arb_pkg::*;

  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ready;
  logic        if_rvalid;
  logic [31:0] if_rdata;

  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ready;
  logic        d_rvalid;
  logic [31:0] d_rdata;

  logic [31:0] mem_addr;
  lanes_t      mem_data_in;
  lanes_t      mem_data_out;
  logic        mem_write_en;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_data_out,
    output if_ready, if_rvalid, if_rdata, d_ready, d_rvalid, d_rdata,
           mem_addr, mem_data_in, mem_write_en
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_data_out,
    input  if_ready, if_rvalid, if_rdata, d_ready, d_rvalid, d_rdata,
           mem_addr, mem_data_in, mem_write_en
  );

endinterface

// File: rtl/mem_port_arbiter_prio.sv
// Winner select between fetch and data requests, with a data-streak limiter
// that forces a fetch grant after DATA_STREAK_MAX data grants while fetch waits.
module mem_arb_prio
  import mem_arb_pkg::*;
#(
  parameter int unsigned DATA_STREAK_MAX = 4
) (
  input  logic   clk,
  input  logic   rst_b,
  input  logic   arb_en,
  input  logic   if_req,
  input  logic   d_req,
  output grant_e grant
);

  localparam int unsigned SW = $clog2(DATA_STREAK_MAX + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(DATA_STREAK_MAX);

  logic [SW-1:0] streak_q, streak_d;

  always_comb begin
    grant = GNT_NONE;
    if (arb_en) begin
      if (d_req && !(if_req && streak_q == STREAK_MAX)) grant = GNT_D;
      else if (if_req)                                  grant = GNT_IF;
    end
  end

  always_comb begin
    streak_d = streak_q;
    if (!if_req || grant == GNT_IF)                   streak_d = '0;
    else if (grant == GNT_D && streak_q != STREAK_MAX) streak_d = streak_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) streak_q <= '0;
    else        streak_q <= streak_d;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one 4-lane memory port between fetch and load/store, one access in flight.
// Optional MEM_ARB_PERF_EN adds per-requester stall-cycle counters.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned MEM_LATENCY     = 2,
  parameter int unsigned DATA_STREAK_MAX = 4
) (
  input  logic                clk,
  input  logic                rst_b,
  input  logic                halted,
  mem_port_arbiter_if.slave   bus
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [31:0]         if_stall_cnt,
  output logic [31:0]         d_stall_cnt
`endif
);

  localparam int unsigned LAT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(MEM_LATENCY - 1);

  arb_state_e        state_q, state_d;
  grant_e            owner_q, owner_d;
  grant_e            grant;
  logic [LAT_W-1:0]  lat_q, lat_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              we_q, we_d;
  logic              wr_en_q, wr_en_d;
  logic              if_rvalid_q, if_rvalid_d;
  logic              d_rvalid_q, d_rvalid_d;
  logic [31:0]       if_rdata_q, if_rdata_d;
  logic [31:0]       d_rdata_q, d_rdata_d;
  logic              arb_en;

  assign arb_en = !halted && (state_q == IDLE || state_q == RESP);

  mem_arb_prio #(
    .DATA_STREAK_MAX(DATA_STREAK_MAX)
  ) u_prio (
    .clk    (clk),
    .rst_b  (rst_b),
    .arb_en (arb_en),
    .if_req (bus.if_req),
    .d_req  (bus.d_req),
    .grant  (grant)
  );

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    lat_d       = lat_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    we_d        = we_q;
    wr_en_d     = 1'b0;
    if_rvalid_d = 1'b0;
    d_rvalid_d  = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    case (state_q)
      IDLE, RESP: begin
        state_d = IDLE;
        if (grant != GNT_NONE) begin
          state_d = ACCESS;
          owner_d = grant;
          lat_d   = LAT_LOAD;
          if (grant == GNT_IF) begin
            addr_d  = bus.if_addr;
            we_d    = 1'b0;
            wdata_d = '0;
          end else begin
            addr_d  = bus.d_addr;
            we_d    = bus.d_we;
            wdata_d = bus.d_wdata;
            wr_en_d = bus.d_we;
          end
        end
      end
      ACCESS: begin
        if (lat_q == '0) begin
          state_d = RESP;
          if (owner_q == GNT_IF) begin
            if_rvalid_d = 1'b1;
            if_rdata_d  = unpack_lanes(bus.mem_data_out);
          end else begin
            d_rvalid_d = 1'b1;
            d_rdata_d  = we_q ? '0 : unpack_lanes(bus.mem_data_out);
          end
        end else begin
          lat_d = lat_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q     <= IDLE;
      owner_q     <= GNT_NONE;
      lat_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      wr_en_q     <= 1'b0;
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      lat_q       <= lat_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      we_q        <= we_d;
      wr_en_q     <= wr_en_d;
      if_rvalid_q <= if_rvalid_d;
      d_rvalid_q  <= d_rvalid_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  assign bus.if_ready     = (grant == GNT_IF);
  assign bus.d_ready      = (grant == GNT_D);
  assign bus.if_rvalid    = if_rvalid_q;
  assign bus.d_rvalid     = d_rvalid_q;
  assign bus.if_rdata     = if_rdata_q;
  assign bus.d_rdata      = d_rdata_q;
  // addr_q only loads on accept, so the port holds its last address between accesses
  assign bus.mem_addr     = addr_q;
  assign bus.mem_write_en = wr_en_q;
  assign bus.mem_data_in  = (state_q == ACCESS && we_q) ? pack_lanes(wdata_q) : '0;

`ifdef MEM_ARB_PERF_EN
  logic [31:0] if_stall_q, if_stall_d;
  logic [31:0] d_stall_q, d_stall_d;

  always_comb begin
    if_stall_d = if_stall_q + {31'd0, (bus.if_req && !bus.if_ready)};
    d_stall_d  = d_stall_q  + {31'd0, (bus.d_req && !bus.d_ready)};
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      if_stall_q <= '0;
      d_stall_q  <= '0;
    end else begin
      if_stall_q <= if_stall_d;
      d_stall_q  <= d_stall_d;
    end
  end

  assign if_stall_cnt = if_stall_q;
  assign d_stall_cnt  = d_stall_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter (MEM_LATENCY=2, DATA_STREAK_MAX=4).
// Stall-counter checks are compiled in only when MEM_ARB_PERF_EN is defined.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  logic clk;
  logic rst_b;
  logic halted;
  int   total;
  int   bad;

`ifdef MEM_ARB_PERF_EN
  logic [31:0] if_stall_cnt;
  logic [31:0] d_stall_cnt;
`endif

  mem_port_arbiter_if bus();

  mem_port_arbiter #(
    .MEM_LATENCY(2),
    .DATA_STREAK_MAX(4)
  ) dut (
    .clk    (clk),
    .rst_b  (rst_b),
    .halted (halted),
    .bus    (bus)
`ifdef MEM_ARB_PERF_EN
    ,
    .if_stall_cnt (if_stall_cnt),
    .d_stall_cnt  (d_stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic set_lanes(input logic [7:0] b0, input logic [7:0] b1,
                           input logic [7:0] b2, input logic [7:0] b3);
    bus.mem_data_out[0] = b0;
    bus.mem_data_out[1] = b1;
    bus.mem_data_out[2] = b2;
    bus.mem_data_out[3] = b3;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int wr_cnt;
    int rdy_cnt;
    int rv_cnt;
    int ng;
    int both;
    logic [9:0] seq;

    total = 0;
    bad = 0;
    rst_b = 1'b0;
    halted = 1'b0;
    bus.if_req = 1'b0;
    bus.if_addr = '0;
    bus.d_req = 1'b0;
    bus.d_we = 1'b0;
    bus.d_addr = '0;
    bus.d_wdata = '0;
    set_lanes(8'h00, 8'h00, 8'h00, 8'h00);

    repeat (3) step();
    chk("rst_if_ready", 32'(bus.if_ready), 32'd0);
    chk("rst_d_ready", 32'(bus.d_ready), 32'd0);
    chk("rst_mem_addr", bus.mem_addr, 32'h0);
    chk("rst_wr_en", 32'(bus.mem_write_en), 32'd0);
    chk("rst_if_rdata", bus.if_rdata, 32'h0);
    chk("rst_d_rvalid", 32'(bus.d_rvalid), 32'd0);
    rst_b = 1'b1;
    step();

    // Fetch from 0x40
    bus.if_req = 1'b1;
    bus.if_addr = 32'h40;
    set_lanes(8'h12, 8'h34, 8'h56, 8'h78);
    @(negedge clk);
    chk("f_ready", 32'(bus.if_ready), 32'd1);
    step();
    bus.if_req = 1'b0;
    @(negedge clk);
    chk("f_addr_t1", bus.mem_addr, 32'h40);
    chk("f_rvalid_t1", 32'(bus.if_rvalid), 32'd0);
    @(negedge clk);
    chk("f_addr_t2", bus.mem_addr, 32'h40);
    chk("f_rvalid_t2", 32'(bus.if_rvalid), 32'd0);
    @(negedge clk);
    chk("f_rvalid_t3", 32'(bus.if_rvalid), 32'd1);
    chk("f_rdata", bus.if_rdata, 32'h12345678);
    @(negedge clk);
    chk("f_rvalid_t4", 32'(bus.if_rvalid), 32'd0);
    chk("f_addr_hold", bus.mem_addr, 32'h40);

    // Load from 0x200
    step();
    bus.d_req = 1'b1;
    bus.d_we = 1'b0;
    bus.d_addr = 32'h200;
    set_lanes(8'hA1, 8'hB2, 8'hC3, 8'hD4);
    @(negedge clk);
    chk("ld_ready", 32'(bus.d_ready), 32'd1);
    step();
    bus.d_req = 1'b0;
    repeat (3) @(negedge clk);
    chk("ld_rvalid", 32'(bus.d_rvalid), 32'd1);
    chk("ld_rdata", bus.d_rdata, 32'hA1B2C3D4);

    // Store 0xDEADBEEF to 0x100
    step();
    bus.d_req = 1'b1;
    bus.d_we = 1'b1;
    bus.d_addr = 32'h100;
    bus.d_wdata = 32'hDEADBEEF;
    @(negedge clk);
    chk("st_ready", 32'(bus.d_ready), 32'd1);
    step();
    bus.d_req = 1'b0;
    wr_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (bus.mem_write_en) wr_cnt++;
      if (i == 0) begin
        chk("st_lanes", {bus.mem_data_in[0], bus.mem_data_in[1],
                         bus.mem_data_in[2], bus.mem_data_in[3]}, 32'hDEADBEEF);
        chk("st_lane0", 32'(bus.mem_data_in[0]), 32'hDE);
        chk("st_addr", bus.mem_addr, 32'h100);
      end
      if (i == 2) begin
        chk("st_rvalid", 32'(bus.d_rvalid), 32'd1);
        chk("st_rdata", bus.d_rdata, 32'h0);
        chk("st_lanes_resp", 32'(bus.mem_data_in), 32'h0);
      end
    end
    chk("st_wr_pulses", wr_cnt, 32'd1);
    bus.d_we = 1'b0;

    // Both requesters held: D,D,D,D,IF,D,D,D,D,IF
    step();
    bus.if_req = 1'b1;
    bus.if_addr = 32'h80;
    bus.d_req = 1'b1;
    bus.d_addr = 32'h180;
    ng = 0;
    both = 0;
    seq = '0;
    for (int c = 0; c < 60 && ng < 10; c++) begin
      @(negedge clk);
      if (bus.if_ready && bus.d_ready) both++;
      if (bus.if_ready) begin
        seq = {seq[8:0], 1'b1};
        ng++;
      end else if (bus.d_ready) begin
        seq = {seq[8:0], 1'b0};
        ng++;
      end
    end
    chk("streak_count", ng, 32'd10);
    chk("streak_seq", 32'(seq), 32'h021);
    chk("streak_both", both, 32'd0);
    step();
    bus.if_req = 1'b0;
    bus.d_req = 1'b0;
    repeat (5) @(negedge clk);

    // Halt after a fetch accept
    step();
    bus.if_req = 1'b1;
    bus.if_addr = 32'h44;
    set_lanes(8'h9A, 8'hBC, 8'hDE, 8'hF0);
    @(negedge clk);
    chk("h_ready", 32'(bus.if_ready), 32'd1);
    step();
    halted = 1'b1;
    bus.d_req = 1'b1;
    bus.d_we = 1'b0;
    bus.d_addr = 32'h600;
    rdy_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (bus.if_ready || bus.d_ready) rdy_cnt++;
      if (i == 2) begin
        chk("h_rvalid", 32'(bus.if_rvalid), 32'd1);
        chk("h_rdata", bus.if_rdata, 32'h9ABCDEF0);
      end
    end
    chk("h_no_ready", rdy_cnt, 32'd0);
    step();
    halted = 1'b0;
    @(negedge clk);
    chk("h_resume_d", 32'(bus.d_ready), 32'd1);
    chk("h_resume_if", 32'(bus.if_ready), 32'd0);
    step();
    bus.if_req = 1'b0;
    bus.d_req = 1'b0;
    repeat (5) @(negedge clk);

    // Reset in the second ACCESS cycle of a load
    step();
    bus.d_req = 1'b1;
    bus.d_addr = 32'h300;
    @(negedge clk);
    chk("r_ready", 32'(bus.d_ready), 32'd1);
    step();
    bus.d_req = 1'b0;
    step();
    rst_b = 1'b0;
    #1;
    chk("r_mem_addr", bus.mem_addr, 32'h0);
    chk("r_if_rdata", bus.if_rdata, 32'h0);
    chk("r_d_rdata", bus.d_rdata, 32'h0);
    rv_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (bus.d_rvalid) rv_cnt++;
    end
    step();
    rst_b = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (bus.d_rvalid) rv_cnt++;
    end
    chk("r_no_rvalid", rv_cnt, 32'd0);

    // After reset: load blocks a pending fetch for 3 cycles
    step();
    bus.d_req = 1'b1;
    bus.d_we = 1'b0;
    bus.d_addr = 32'h400;
    bus.if_req = 1'b1;
    bus.if_addr = 32'h500;
    set_lanes(8'h11, 8'h22, 8'h33, 8'h44);
    @(negedge clk);
    chk("p_d_ready", 32'(bus.d_ready), 32'd1);
    chk("p_if_wait", 32'(bus.if_ready), 32'd0);
    step();
    bus.d_req = 1'b0;
    repeat (3) @(negedge clk);
    chk("p_d_rvalid", 32'(bus.d_rvalid), 32'd1);
    chk("p_d_rdata", bus.d_rdata, 32'h11223344);
    chk("p_if_ready", 32'(bus.if_ready), 32'd1);
    step();
    bus.if_req = 1'b0;
    set_lanes(8'h55, 8'h66, 8'h77, 8'h88);
    repeat (3) @(negedge clk);
    chk("p_if_rvalid", 32'(bus.if_rvalid), 32'd1);
    chk("p_if_rdata", bus.if_rdata, 32'h55667788);
`ifdef MEM_ARB_PERF_EN
    chk("p_if_stall", if_stall_cnt, 32'd3);
    chk("p_d_stall", d_stall_cnt, 32'd0);
`endif

    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
